add_sub: RTL and testbench
==========================

# add_sub

Parameterised N-bit ripple-carry adder/subtractor with a registered result. A single mode input selects A+B or A−B (two's complement, B inverted and mode fed in as carry-in). The full internal carry chain is exported alongside the sum/difference. It sits in the datapath as the basic arithmetic primitive feeding ALU and counter logic.

## Interface
Parameters:
- N, default 4, operand width in bits (N ≥ 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- a  in  N  operand A (minuend for subtract).
- b  in  N  operand B (subtrahend for subtract).
- cin  in  1  mode: 0 = add, 1 = subtract; also the carry-in of bit 0.
- s  out  N  registered sum/difference.
- c  out  N+1  registered carry chain; c[0] = cin, c[N] = carry-out.
- ovf  out  1  registered signed overflow; present only with ADD_SUB_OVERFLOW_EN.

## Operation
- b_eff[i] = b[i] ^ cin.
- Carry chain: c[0] = cin; for i in 0..N−1: s[i] = a[i] ^ b_eff[i] ^ c[i], c[i+1] = a[i]&b_eff[i] | c[i]&(a[i]^b_eff[i]).
- Add: {c[N], s} = a + b, unsigned.
- Subtract: s = (a − b) mod 2^N. c[N] = 1 means no borrow (a ≥ b unsigned). c[N] = 0 means borrow (a < b).
- Wrap-around is modulo 2^N with no saturation. Examples: 1111 + 0001 → s = 0000, c[N] = 1. 0000 − 0001 → s = 1111, c[N] = 0.
- ovf = c[N] ^ c[N−1]: signed two's-complement overflow of the operation.
- All intermediate carries c[1..N−1] are visible on c for debug and chaining.

## Timing
- The combinational chain evaluates the a, b, cin values present at each rising clk edge; s, c and ovf update on that edge.
- Latency is 1 cycle and throughput is 1 operation per cycle. There is no handshake, and the block accepts new operands every cycle.
- Reset: when rst_n goes low, s, c and ovf clear to 0 immediately, regardless of clk.
- While rst_n is low, the outputs hold 0.
- The first capture happens on the first rising clk edge after rst_n deasserts.
- Reset asserted mid-stream discards the in-flight result; no partial update is allowed.
- A change of cin between edges has no effect until the next edge.

## Configuration
- ADD_SUB_OVERFLOW_EN defined: the ovf port and its register exist, with behaviour as above.
- ADD_SUB_OVERFLOW_EN undefined: there is no ovf port and no overflow logic. s and c behaviour is identical in both builds.

## Structure
- Shared package add_sub_pkg holds:
  - ADD_SUB_WIDTH_DEF = 4.
  - the mode constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
- One sub-module, full_adder (inputs a, b, ci; outputs s, co), instantiated N times in a generate loop.
- The top level holds the B-inversion XORs, the output registers and the optional overflow logic.

## Test plan
- Add, N=4: a=0010, b=0110, cin=0 → next edge: s=1000, c=01100, ovf=1 (2+6 exceeds signed range).
- Subtract with borrow: a=0010, b=0110, cin=1 → s=1100, c=00111, c[4]=0, ovf=0.
- Subtract sweep: b=0110, cin=1, a stepping 0010→1010 once per cycle. Each cycle s = a−6 mod 16, delayed 1 cycle. c[4]=0 for a<6 and 1 for a≥6; a=0110 → s=0000, c[4]=1; a=1010 → s=0100.
- Wrap-around: a=1111, b=0001, cin=0 → s=0000, c[4]=1, ovf=0. Then a=0000, b=0001, cin=1 → s=1111, c[4]=0.
- Async reset: drive operands, pulse rst_n low between clock edges → s=0000, c=00000, ovf=0 within the same cycle. Outputs stay 0 until the first edge after release.
- Width scaling: N=8, a=0x7F, b=0x01, cin=0 → s=0x80, c[8]=0, ovf=1.

Source files
------------

// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared width default and mode constants for add_sub
package add_sub_pkg;

    localparam int ADD_SUB_WIDTH_DEF = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : add_sub_pkg

// File: rtl/add_sub_if.sv
// rtl/add_sub_if.sv - operand/result bundle for add_sub; ovf exists only with ADD_SUB_OVERFLOW_EN
interface add_sub_if
    import add_sub_pkg::*;
#(
    parameter int N = ADD_SUB_WIDTH_DEF
);

    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic [N:0]   c;
`ifdef ADD_SUB_OVERFLOW_EN
    logic         ovf;

    modport master (output a, output b, output cin, input s, input c, input ovf);
    modport slave  (input a, input b, input cin, output s, output c, output ovf);
`else
    modport master (output a, output b, output cin, input s, input c);
    modport slave  (input a, input b, input cin, output s, output c);
`endif

endinterface : add_sub_if

// File: rtl/add_sub_full_adder.sv
// rtl/add_sub_full_adder.sv - one-bit full adder cell of the ripple chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder

// File: rtl/add_sub.sv
// rtl/add_sub.sv - registered N-bit ripple adder/subtractor exporting its carry chain
// Signed overflow output and register are built only with ADD_SUB_OVERFLOW_EN.
module add_sub
    import add_sub_pkg::*;
#(
    parameter int N = ADD_SUB_WIDTH_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    add_sub_if.slave bus
);

    logic [N-1:0] b_eff;
    logic [N:0]   carry;
    logic [N-1:0] sum;

    logic [N-1:0] s_d, s_q;
    logic [N:0]   c_d, c_q;

    // Subtract is a + ~b + 1: the mode bit doubles as the carry into bit 0.
    assign b_eff    = (bus.cin == MODE_SUB) ? ~bus.b : bus.b;
    assign carry[0] = bus.cin;

    for (genvar i = 0; i < N; i++) begin : g_chain
        full_adder u_fa (
            .a  (bus.a[i]),
            .b  (b_eff[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_comb begin
        s_d = sum;
        c_d = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            c_q <= '0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign bus.s = s_q;
    assign bus.c = c_q;

`ifdef ADD_SUB_OVERFLOW_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = carry[N] ^ carry[N-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule : add_sub

// File: tb/tb_add_sub.sv
// tb/tb_add_sub.sv - scoreboard bench for add_sub at N=4 and N=8 (ovf checked with ADD_SUB_OVERFLOW_EN)
module tb_add_sub;

    typedef struct {
        logic [15:0] s;
        logic [16:0] c;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t q4[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    add_sub_if #(.N(4)) bus4 ();
    add_sub_if #(.N(8)) bus8 ();

    add_sub #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    add_sub #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Carry into bit i is bit i of the sum of the operands' low i bits plus carry-in.
    function automatic exp_t model(input int w, input int a, input int b, input logic ci);
        exp_t e;
        int   mask, be, t, sv;
        logic sa, sb;
        mask = (1 << w) - 1;
        be   = ci ? (~b & mask) : (b & mask);
        e.c  = '0;
        for (int i = 0; i <= w; i++) begin
            t = (a & ((1 << i) - 1)) + (be & ((1 << i) - 1)) + int'(ci);
            e.c[i] = t[i];
        end
        sv  = (a + be + int'(ci)) & mask;
        e.s = 16'(sv);
        sa  = a[w-1];
        sb  = b[w-1];
        if (ci) e.ovf = (sa != sb) && (sv[w-1] != sa);
        else    e.ovf = (sa == sb) && (sv[w-1] != sa);
        return e;
    endfunction

    task automatic drive4(input int a, input int b, input logic ci);
        bus4.a   = 4'(a);
        bus4.b   = 4'(b);
        bus4.cin = ci;
        q4.push_back(model(4, a, b, ci));
    endtask

    task automatic drive8(input int a, input int b, input logic ci);
        bus8.a   = 8'(a);
        bus8.b   = 8'(b);
        bus8.cin = ci;
        q8.push_back(model(8, a, b, ci));
    endtask

    task automatic collect4(input string tag);
        exp_t e;
        if (q4.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = q4.pop_front();
            check({tag, ".s"}, 17'(bus4.s), 17'(e.s[3:0]));
            check({tag, ".c"}, 17'(bus4.c), 17'(e.c[4:0]));
`ifdef ADD_SUB_OVERFLOW_EN
            check({tag, ".ovf"}, 17'(bus4.ovf), 17'(e.ovf));
`endif
        end
    endtask

    task automatic collect8(input string tag);
        exp_t e;
        if (q8.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = q8.pop_front();
            check({tag, ".s"}, 17'(bus8.s), 17'(e.s[7:0]));
            check({tag, ".c"}, 17'(bus8.c), 17'(e.c[8:0]));
`ifdef ADD_SUB_OVERFLOW_EN
            check({tag, ".ovf"}, 17'(bus8.ovf), 17'(e.ovf));
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".s4"}, 17'(bus4.s), 17'd0);
        check({tag, ".c4"}, 17'(bus4.c), 17'd0);
        check({tag, ".s8"}, 17'(bus8.s), 17'd0);
        check({tag, ".c8"}, 17'(bus8.c), 17'd0);
`ifdef ADD_SUB_OVERFLOW_EN
        check({tag, ".ovf4"}, 17'(bus4.ovf), 17'd0);
        check({tag, ".ovf8"}, 17'(bus8.ovf), 17'd0);
`endif
    endtask

    initial begin
        bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;

        #3;
        check_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // add 2+6: signed overflow into 1000
        @(negedge clk);
        drive4(2, 6, 1'b0);
        @(posedge clk); #1;
        check("add_lit.s", 17'(bus4.s), 17'b1000);
        check("add_lit.c", 17'(bus4.c), 17'b01100);
`ifdef ADD_SUB_OVERFLOW_EN
        check("add_lit.ovf", 17'(bus4.ovf), 17'd1);
`endif
        collect4("add_2_6");

        // subtract 2-6 with borrow
        @(negedge clk);
        drive4(2, 6, 1'b1);
        @(posedge clk); #1;
        check("sub_lit.s", 17'(bus4.s), 17'b1100);
        check("sub_lit.c", 17'(bus4.c), 17'b00111);
        collect4("sub_2_6");

        // sweep a = 2..10 minus 6, one operation per cycle
        for (int a = 2; a <= 10; a++) begin
            @(negedge clk);
            drive4(a, 6, 1'b1);
            @(posedge clk); #1;
            check($sformatf("sweep_a%0d.borrow", a), 17'(bus4.c[4]), 17'(a >= 6));
            collect4($sformatf("sweep_a%0d", a));
        end

        // wrap-around in both directions
        @(negedge clk);
        drive4(15, 1, 1'b0);
        @(posedge clk); #1;
        check("wrap_add.s", 17'(bus4.s), 17'd0);
        check("wrap_add.cout", 17'(bus4.c[4]), 17'd1);
        collect4("wrap_add");
        @(negedge clk);
        drive4(0, 1, 1'b1);
        @(posedge clk); #1;
        check("wrap_sub.s", 17'(bus4.s), 17'b1111);
        check("wrap_sub.cout", 17'(bus4.c[4]), 17'd0);
        collect4("wrap_sub");

        // mixed patterns, 8-bit instance in parallel
        @(negedge clk);
        drive4(7, 1, 1'b0);
        drive8(8'h7F, 8'h01, 1'b0);
        @(posedge clk); #1;
        check("w8.s", 17'(bus8.s), 17'h80);
        check("w8.cout", 17'(bus8.c[8]), 17'd0);
`ifdef ADD_SUB_OVERFLOW_EN
        check("w8.ovf", 17'(bus8.ovf), 17'd1);
`endif
        collect4("add_7_1");
        collect8("w8_7f_01");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive4((k * 5 + 3) % 16, (k * 7 + 9) % 16, logic'(k[0]));
            drive8((k * 53 + 128) % 256, (k * 91 + 17) % 256, logic'(k[1]));
            @(posedge clk); #1;
            collect4($sformatf("mix4_%0d", k));
            collect8($sformatf("mix8_%0d", k));
        end

        // cin change between edges only matters at the next edge
        @(negedge clk);
        drive4(9, 3, 1'b0);
        @(posedge clk); #1;
        bus4.cin = 1'b1;
        #2;
        collect4("cin_hold");
        q4.push_back(model(4, 9, 3, 1'b1));
        @(posedge clk); #1;
        collect4("cin_next");

        // async reset between edges discards the in-flight result
        @(negedge clk);
        drive4(5, 3, 1'b0);
        @(posedge clk); #1;
        collect4("pre_reset");
        @(negedge clk);
        drive4(1, 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        q4.delete();
        q8.delete();
        @(posedge clk); #1;
        check_zero("reset_hold");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_zero("reset_release");
        drive4(1, 1, 1'b0);
        drive8(8'h10, 8'h20, 1'b1);
        @(posedge clk); #1;
        collect4("post_reset");
        collect8("post_reset8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        total++;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_add_sub
